traffic_request_conditioner: RTL and testbench

TRAFFIC_REQUEST_CONDITIONER -- requirements
Module: traffic_request_conditioner

---
 rtl/traffic_request_conditioner_pkg.sv | 25 ++
 rtl/traffic_request_conditioner_if.sv | 30 +++
 rtl/traffic_request_conditioner_input_debouncer.sv | 49 ++++
 rtl/traffic_request_conditioner.sv | 103 ++++++++++
 tb/tb_traffic_request_conditioner.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_request_conditioner_pkg.sv
// Shared traffic definitions: light and walk encodings, debounce counter width
// and a one-hot helper used by the fault monitor.
package traffic_request_conditioner_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    LIGHT_RED    = 3'b001,
    LIGHT_YELLOW = 3'b010,
    LIGHT_GREEN  = 3'b100
  } light_e;

  typedef enum logic [1:0] {
    WALK_NONE = 2'b00,
    WALK_EW   = 2'b01,
    WALK_NS   = 2'b10,
    WALK_BOTH = 2'b11
  } walk_e;

  // True when exactly one of the three light bits is set.
  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == LIGHT_RED) || (v == LIGHT_YELLOW) || (v == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/traffic_request_conditioner_if.sv
// Signal bundle between the traffic light controller and the request
// conditioner. Light inputs are plain vectors so illegal codes reach the
// fault monitor untouched.
interface traffic_request_conditioner_if;
  import traffic_request_conditioner_pkg::*;

  logic       raw_car_ns;
  logic       raw_car_ew;
  logic       raw_ped;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic [1:0] light_ped;
  logic       car_ns;
  logic       car_ew;
  logic       ped;
  logic       fault;

  // Controller/sensor side: drives raw levels and light state.
  modport master (
    output raw_car_ns, raw_car_ew, raw_ped, light_ns, light_ew, light_ped,
    input  car_ns, car_ew, ped, fault
  );

  // Conditioner side.
  modport slave (
    input  raw_car_ns, raw_car_ew, raw_ped, light_ns, light_ew, light_ped,
    output car_ns, car_ew, ped, fault
  );

endinterface

// File: rtl/traffic_request_conditioner_input_debouncer.sv
// Per-channel conditioner: two-flop synchronizer followed by a stability
// counter that flips the filtered level after DEBOUNCE_CYCLES consecutive
// synchronized samples that disagree with it.
module input_debouncer
  import traffic_request_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the asynchronous level into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking keeps these as two distinct stages; a blocking
      // assignment would make sync_q see raw in the same edge.
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Count disagreeing samples; the last one flips the level and restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (sync_q == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == LAST_CNT) begin
      stable_cnt <= '0;
      level      <= ~level;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_request_conditioner.sv
// Conditions raw car sensors and the pedestrian button into clean request
// flags for the traffic light controller, and flags illegal light states.
module traffic_request_conditioner
  import traffic_request_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                          clk,
  input logic                          rst,
  traffic_request_conditioner_if.slave bus
);

  logic filt_ns;
  logic filt_ew;
  logic filt_ped;
  logic filt_ped_q;
  logic ped_rise;
  logic illegal_lights;
  logic car_ns_q;
  logic car_ew_q;
  logic ped_q;
  logic fault_q;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ns (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.raw_car_ns),
    .level (filt_ns)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ew (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.raw_car_ew),
    .level (filt_ew)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ped (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.raw_ped),
    .level (filt_ped)
  );

  // A held button must yield one request, so only the press edge counts.
  assign ped_rise = filt_ped & ~filt_ped_q;

  // Detect light combinations the controller must never produce.
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    illegal_lights = 1'b0;
    if (!is_one_hot3(bus.light_ns) || !is_one_hot3(bus.light_ew)) begin
      illegal_lights = 1'b1;
    end else if ((bus.light_ns != LIGHT_RED) && (bus.light_ew != LIGHT_RED)) begin
      illegal_lights = 1'b1;
    end
  end

  // Request registers: serving the direction (or walk) clears, clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      car_ns_q   <= 1'b0;
      car_ew_q   <= 1'b0;
      ped_q      <= 1'b0;
      filt_ped_q <= 1'b0;
    end else begin
      if (bus.light_ns == LIGHT_GREEN) begin
        car_ns_q <= 1'b0;
      end else if (filt_ns) begin
        car_ns_q <= 1'b1;
      end

      if (bus.light_ew == LIGHT_GREEN) begin
        car_ew_q <= 1'b0;
      end else if (filt_ew) begin
        car_ew_q <= 1'b1;
      end

      if (bus.light_ped == WALK_BOTH) begin
        ped_q <= 1'b0;
      end else if (ped_rise) begin
        ped_q <= 1'b1;
      end

      filt_ped_q <= filt_ped;
    end
  end

  // Sticky fault flag; only reset clears it, and it never gates requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (illegal_lights) begin
      fault_q <= 1'b1;
    end
  end

  assign bus.car_ns = car_ns_q;
  assign bus.car_ew = car_ew_q;
  assign bus.ped    = ped_q;
  assign bus.fault  = fault_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Self-checking bench for traffic_request_conditioner: directed scenarios then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_traffic_request_conditioner;
  import traffic_request_conditioner_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  traffic_request_conditioner_if tif ();

  traffic_request_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  bit m_dly [3][$];   // raw samples not yet seen by the filter (2-edge delay)
  bit m_run [3][$];   // current run of samples disagreeing with the level
  bit m_filt [3];
  bit m_ped_prev;
  bit m_car_ns, m_car_ew, m_ped, m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit lights_illegal(input logic [2:0] ns, input logic [2:0] ew);
    if ($countones(ns) != 1 || $countones(ew) != 1) return 1'b1;
    return (ns != 3'b001) && (ew != 3'b001);
  endfunction

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    bit raw [3];
    bit s;
    raw[0] = tif.raw_car_ns;
    raw[1] = tif.raw_car_ew;
    raw[2] = tif.raw_ped;
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        m_dly[ch]  = '{1'b0, 1'b0};
        m_run[ch].delete();
        m_filt[ch] = 1'b0;
      end
      m_ped_prev = 1'b0;
      m_car_ns   = 1'b0;
      m_car_ew   = 1'b0;
      m_ped      = 1'b0;
      m_fault    = 1'b0;
      return;
    end
    if (tif.light_ns == 3'b100) m_car_ns = 1'b0;
    else if (m_filt[0]) m_car_ns = 1'b1;
    if (tif.light_ew == 3'b100) m_car_ew = 1'b0;
    else if (m_filt[1]) m_car_ew = 1'b1;
    if (tif.light_ped == 2'b11) m_ped = 1'b0;
    else if (m_filt[2] && !m_ped_prev) m_ped = 1'b1;
    m_ped_prev = m_filt[2];
    if (lights_illegal(tif.light_ns, tif.light_ew)) m_fault = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      s = m_dly[ch].pop_front();
      m_dly[ch].push_back(raw[ch]);
      if (s == m_filt[ch]) begin
        m_run[ch].delete();
      end else begin
        m_run[ch].push_back(s);
        if (m_run[ch].size() == D) begin
          m_filt[ch] = ~m_filt[ch];
          m_run[ch].delete();
        end
      end
    end
  endtask

  // One clock: update model at the edge, compare outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("car_ns", 32'(tif.car_ns), 32'(m_car_ns));
    check("car_ew", 32'(tif.car_ew), 32'(m_car_ew));
    check("ped",    32'(tif.ped),    32'(m_ped));
    check("fault",  32'(tif.fault),  32'(m_fault));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [2:0] legal_ns [5] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b001};
  logic [2:0] legal_ew [5] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010};
  bit         bounce   [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    int edge_at;
    int rises;
    logic prev_ped;
    int idx;

    rst            = 1'b1;
    tif.raw_car_ns = 1'b0;
    tif.raw_car_ew = 1'b0;
    tif.raw_ped    = 1'b0;
    tif.light_ns   = LIGHT_RED;
    tif.light_ew   = LIGHT_RED;
    tif.light_ped  = WALK_NONE;
    run(2);
    rst = 1'b0;
    step();
    check("reset_outputs", 32'({tif.car_ns, tif.car_ew, tif.ped, tif.fault}), 32'(0));

    // NS car held: rises on edge 7, green clears it, then it re-asserts.
    tif.raw_car_ns = 1'b1;
    edge_at = 0;
    for (int e = 1; e <= 12 && edge_at == 0; e++) begin
      step();
      if (tif.car_ns === 1'b1) edge_at = e;
    end
    check("ns_latency", 32'(edge_at), 32'(7));
    tif.light_ns = LIGHT_GREEN;
    step();
    check("ns_green_clear", 32'(tif.car_ns), 32'(0));
    tif.light_ns = LIGHT_RED;
    step();
    check("ns_reassert", 32'(tif.car_ns), 32'(1));
    tif.raw_car_ns = 1'b0;
    run(8);
    tif.light_ns = LIGHT_GREEN;
    step();
    tif.light_ns = LIGHT_RED;
    run(2);

    // Short ped glitch ignored; long press gives exactly one sticky request.
    do_reset();
    tif.raw_ped = 1'b1;
    run(3);
    tif.raw_ped = 1'b0;
    run(10);
    check("ped_glitch", 32'(tif.ped), 32'(0));
    tif.raw_ped = 1'b1;
    rises = 0;
    prev_ped = tif.ped;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) tif.raw_ped = 1'b0;
      step();
      if (tif.ped === 1'b1 && prev_ped !== 1'b1) rises++;
      prev_ped = tif.ped;
    end
    check("ped_one_rise", 32'(rises), 32'(1));
    check("ped_sticky", 32'(tif.ped), 32'(1));
    tif.light_ped = WALK_BOTH;
    step();
    check("ped_walk_clear", 32'(tif.ped), 32'(0));
    tif.light_ped = WALK_NONE;
    run(2);

    // Press during a walk phase is discarded; a later press is accepted.
    tif.light_ped = WALK_BOTH;
    tif.raw_ped   = 1'b1;
    run(10);
    tif.raw_ped = 1'b0;
    run(10);
    check("ped_walk_discard", 32'(tif.ped), 32'(0));
    tif.light_ped = WALK_NONE;
    step();
    tif.raw_ped = 1'b1;
    run(10);
    check("ped_after_walk", 32'(tif.ped), 32'(1));
    tif.raw_ped   = 1'b0;
    tif.light_ped = WALK_BOTH;
    step();
    tif.light_ped = WALK_NONE;
    run(8);

    // Reset mid-debounce discards the count; full latency after release.
    do_reset();
    tif.raw_car_ew = 1'b1;
    run(2);
    rst = 1'b1;
    step();
    check("rst_mid_outputs", 32'({tif.car_ns, tif.car_ew, tif.ped, tif.fault}), 32'(0));
    rst = 1'b0;
    edge_at = 0;
    for (int e = 1; e <= 12 && edge_at == 0; e++) begin
      step();
      if (tif.car_ew === 1'b1) edge_at = e;
    end
    check("ew_latency_after_rst", 32'(edge_at), 32'(7));
    tif.raw_car_ew = 1'b0;
    tif.light_ew   = LIGHT_GREEN;
    run(8);
    tif.light_ew = LIGHT_RED;
    step();

    // Fault: green/green for one cycle is sticky until reset.
    do_reset();
    tif.light_ns = LIGHT_GREEN;
    tif.light_ew = LIGHT_GREEN;
    step();
    check("fault_set", 32'(tif.fault), 32'(1));
    tif.light_ns = LIGHT_RED;
    tif.light_ew = LIGHT_RED;
    run(22);
    check("fault_sticky", 32'(tif.fault), 32'(1));
    rst = 1'b1;
    step();
    check("fault_rst", 32'(tif.fault), 32'(0));
    tif.light_ns = 3'b011;
    rst = 1'b0;
    step();
    check("fault_not_one_hot", 32'(tif.fault), 32'(1));
    tif.light_ns = LIGHT_RED;
    do_reset();

    // Bounce on EW: only the final run of four 1s is accepted.
    edge_at = 0;
    for (int e = 1; e <= 20 && edge_at == 0; e++) begin
      tif.raw_car_ew = (e <= 9) ? bounce[e-1] : 1'b1;
      step();
      if (tif.car_ew === 1'b1) edge_at = e;
    end
    check("ew_bounce_edge", 32'(edge_at), 32'(12));
    tif.raw_car_ew = 1'b0;
    tif.light_ew   = LIGHT_GREEN;
    run(8);
    tif.light_ew = LIGHT_RED;
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) tif.raw_car_ns = ~tif.raw_car_ns;
      if ($urandom_range(0, 7) == 0) tif.raw_car_ew = ~tif.raw_car_ew;
      if ($urandom_range(0, 7) == 0) tif.raw_ped    = ~tif.raw_ped;
      if ($urandom_range(0, 9) == 0) begin
        idx          = int'($urandom_range(0, 4));
        tif.light_ns = legal_ns[idx];
        tif.light_ew = legal_ew[idx];
      end
      if ($urandom_range(0, 199) == 0) begin
        tif.light_ns = 3'($urandom_range(0, 7));
        tif.light_ew = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 5) == 0) tif.light_ped = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 249) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
